// File: rtl/fp_ctrl_pkg.sv
// Shared encodings for the FP multi-cycle control path: opcodes, funcs, ALU codes, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_ctrl_pkg;

    localparam logic [5:0] OP_FP   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_SW   = 6'b110010;
    localparam logic [5:0] OP_ADDI = 6'b110011;
    localparam logic [5:0] OP_LUI  = 6'b110100;

    localparam logic [5:0] FN_ADD   = 6'b000000;
    localparam logic [5:0] FN_SUB   = 6'b000001;
    localparam logic [5:0] FN_MULT  = 6'b000010;
    localparam logic [5:0] FN_DIV   = 6'b000011;
    localparam logic [5:0] FN_CEQ   = 6'b000100;
    localparam logic [5:0] FN_CLE   = 6'b000101;
    localparam logic [5:0] FN_CLT   = 6'b000110;
    localparam logic [5:0] FN_NEG   = 6'b000111;
    localparam logic [5:0] FN_ROUND = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_MULT  = 4'b0010;
    localparam logic [3:0] ALU_DIV   = 4'b0011;
    localparam logic [3:0] ALU_CEQ   = 4'b0100;
    localparam logic [3:0] ALU_CLE   = 4'b0101;
    localparam logic [3:0] ALU_CLT   = 4'b0110;
    localparam logic [3:0] ALU_NEG   = 4'b0111;
    localparam logic [3:0] ALU_ROUND = 4'b1000;
    localparam logic [3:0] ALU_LW    = 4'b1001;
    localparam logic [3:0] ALU_SW    = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       dst_reg;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_wr;
        logic       reg_wr;
    } ctrl_t;

    typedef enum logic [1:0] {LAT_ARITH, LAT_MUL, LAT_DIV, LAT_MEM} lat_cls_t;

    // Memory/immediate class: rt destination, immediate operand.
    function automatic ctrl_t mem_ctrl(input logic [3:0] alu, input logic m2r,
                                       input logic mw, input logic rw);
        ctrl_t c;
        c.alu_control = alu;
        c.dst_reg     = 1'b0;
        c.alu_src     = 1'b1;
        c.mem_to_reg  = m2r;
        c.mem_wr      = mw;
        c.reg_wr      = rw;
        return c;
    endfunction

endpackage

// File: rtl/fp_ctrl_decode.sv
// Decodes opcode/func into a control word, a latency class and an illegal flag.
// Latency: combinational.
// Backpressure: none; outputs only matter when the top accepts an instruction.
module fp_ctrl_decode
    import fp_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output ctrl_t      ctrl,
    output lat_cls_t   lat_cls,
    output logic       illegal
);

    // Table lookup; unknown opcode or unknown FP func raises illegal.
    always_comb begin
        ctrl    = '0;
        lat_cls = LAT_ARITH;
        illegal = 1'b0;
        case (opcode)
            OP_FP: begin
                ctrl.dst_reg = 1'b1;
                ctrl.reg_wr  = 1'b1;
                case (func)
                    FN_ADD:   ctrl.alu_control = ALU_ADD;
                    FN_SUB:   ctrl.alu_control = ALU_SUB;
                    FN_MULT: begin
                        ctrl.alu_control = ALU_MULT;
                        lat_cls          = LAT_MUL;
                    end
                    FN_DIV: begin
                        ctrl.alu_control = ALU_DIV;
                        lat_cls          = LAT_DIV;
                    end
                    FN_CEQ:   ctrl.alu_control = ALU_CEQ;
                    FN_CLE:   ctrl.alu_control = ALU_CLE;
                    FN_CLT:   ctrl.alu_control = ALU_CLT;
                    FN_NEG:   ctrl.alu_control = ALU_NEG;
                    FN_ROUND: ctrl.alu_control = ALU_ROUND;
                    default:  illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl    = mem_ctrl(ALU_LW, 1'b1, 1'b0, 1'b1);
                lat_cls = LAT_MEM;
            end
            OP_SW: begin
                ctrl    = mem_ctrl(ALU_SW, 1'b0, 1'b1, 1'b0);
                lat_cls = LAT_MEM;
            end
            OP_ADDI: begin
                ctrl    = mem_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b1);
                lat_cls = LAT_MEM;
            end
            OP_LUI: begin
                ctrl    = mem_ctrl(ALU_LUI, 1'b0, 1'b0, 1'b1);
                lat_cls = LAT_MEM;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fp_mc_ctrl.sv
// Multi-cycle FP control: latches a decoded control word and holds it for the op's latency.
// Latency: control word live cycles T+1..T+L after accept at edge T; strobes/done in cycle T+L only.
// Backpressure: instr_ready low while an op is in flight (except its done cycle), during flush and rst.
module fp_mc_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int ARITH_LAT  = 2,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 12,
    parameter int MEM_LAT    = 1,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic                  flush,
    output logic                  instr_ready,
    output logic                  stall,
    output logic                  ctrl_valid,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  dstReg,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  done,
    output logic                  illegal
);

    localparam int MAX_AM  = (ARITH_LAT > MEM_LAT) ? ARITH_LAT : MEM_LAT;
    localparam int MAX_MD  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MAX_LAT = (MAX_AM > MAX_MD) ? MAX_AM : MAX_MD;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    if (ARITH_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || MEM_LAT < 1) begin : g_bad_lat
        $error("fp_mc_ctrl: every op latency must be at least 1");
    end
    if (ALU_CTRL_W < 4) begin : g_bad_alu_w
        $error("fp_mc_ctrl: ALU_CTRL_W must be at least 4");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    ctrl_t            ctrl_q;
    logic             ctrl_valid_q;
    logic             illegal_q;

    ctrl_t            dec_ctrl;
    lat_cls_t         dec_cls;
    logic             dec_illegal;
    logic             done_int;
    logic             accept;
    logic [ALU_CTRL_W-1:0] alu_ext;

    fp_ctrl_decode u_decode (
        .opcode  (opcode),
        .func    (func),
        .ctrl    (dec_ctrl),
        .lat_cls (dec_cls),
        .illegal (dec_illegal)
    );

    function automatic logic [CNT_W-1:0] lat_of(input lat_cls_t cls);
        case (cls)
            LAT_ARITH: return CNT_W'(ARITH_LAT);
            LAT_MUL:   return CNT_W'(MUL_LAT);
            LAT_DIV:   return CNT_W'(DIV_LAT);
            LAT_MEM:   return CNT_W'(MEM_LAT);
        endcase
    endfunction

    assign done_int    = (state == BUSY) && (cnt == CNT_W'(1));
    assign instr_ready = ~rst & ~flush & ((state == IDLE) | done_int);
    assign accept      = instr_valid & instr_ready;
    assign stall       = instr_valid & ~instr_ready;

    // Completion strobes are suppressed by flush/rst so an aborted op never writes back.
    assign done     = done_int & ~flush & ~rst;
    assign RegWrite = done & ctrl_q.reg_wr;
    assign MemWrite = done & ctrl_q.mem_wr;

    // Zero-extend the 4-bit ALU code to the configured port width.
    always_comb begin
        alu_ext      = '0;
        alu_ext[3:0] = ctrl_q.alu_control;
    end

    assign alu_control = alu_ext;
    assign dstReg      = ctrl_q.dst_reg;
    assign ALUSrc      = ctrl_q.alu_src;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign ctrl_valid  = ctrl_valid_q;
    assign illegal     = illegal_q;

    // IDLE/BUSY FSM with latency down-counter; accept in the done cycle reloads without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (flush) begin
                state        <= IDLE;
                cnt          <= '0;
                ctrl_valid_q <= 1'b0;
            end else if (accept) begin
                if (dec_illegal) begin
                    state        <= IDLE;
                    cnt          <= '0;
                    ctrl_valid_q <= 1'b0;
                    illegal_q    <= 1'b1;
                end else begin
                    ctrl_q       <= dec_ctrl;
                    cnt          <= lat_of(dec_cls);
                    state        <= BUSY;
                    ctrl_valid_q <= 1'b1;
                end
            end else if (state == BUSY) begin
                if (done_int) begin
                    state        <= IDLE;
                    cnt          <= '0;
                    ctrl_valid_q <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
